// File: rtl/shift_right_iter.sv
// rtl/shift_right_iter.sv - iterative 32-bit right shifter, one log-shifter stage per cycle
module shift_right_iter (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    input  logic        arith,
    output logic        in_ready,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] work_q;
    logic [31:0] work_d;
    logic        sign_q;
    logic [4:0]  shamt_q;
    logic        arith_q;
    logic [2:0]  stage_q;
    logic [31:0] data_out_q;
    logic        in_ready_q;
    logic        busy_q;
    logic        out_valid_q;

    logic        fill;
    logic [4:0]  stage_amt;
    logic [31:0] stage_shifted;

    // One shifter stage: shift by 2^stage when that shamt bit is set. Fill
    // comes from the sign of the original operand, not the working value.
    always_comb begin
        fill          = arith_q & sign_q;
        stage_amt     = 5'd1 << stage_q;
        stage_shifted = (work_q >> stage_amt)
                      | (fill ? ~(32'hFFFF_FFFF >> stage_amt) : 32'h0);
        work_d        = shamt_q[stage_q] ? stage_shifted : work_q;
    end

    // Control FSM with registered handshake flags; data_out only loads the final stage.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            work_q      <= 32'h0;
            sign_q      <= 1'b0;
            shamt_q     <= 5'h0;
            arith_q     <= 1'b0;
            stage_q     <= 3'h0;
            data_out_q  <= 32'h0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        work_q     <= data_in;
                        sign_q     <= data_in[31];
                        shamt_q    <= shamt;
                        arith_q    <= arith;
                        stage_q    <= 3'h0;
                        state_q    <= SHIFT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    if (stage_q == 3'd4) begin
                        data_out_q  <= work_d;
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        stage_q <= stage_q + 3'd1;
                    end
                end
                DONE: begin
                    // Leaving DONE never accepts; in_ready rises on this edge so
                    // the earliest accept is the following edge.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

endmodule

// File: doc/shift_right_iter.md
SHIFT_RIGHT_ITER -- requirements
Module: shift_right_iter

Interface
REQ-001 SHALL have no parameters; data width fixed at 32 bits, shift amount fixed at 5 bits.
REQ-002 SHALL have port clock, input, 1, sole clock, all state updates on rising edge.
REQ-003 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to accept a new operation.
REQ-005 SHALL have port data_in, input, 32, operand to be shifted right.
REQ-006 SHALL have port shamt, input, 5, shift distance 0..31.
REQ-007 SHALL have port arith, input, 1, 1 = arithmetic (sign fill), 0 = logical (zero fill).
REQ-008 SHALL have port in_ready, output, 1, high when an operation can be accepted.
REQ-009 SHALL have port busy, output, 1, high while shifting stages are in progress.
REQ-010 SHALL have port out_valid, output, 1, result on data_out is valid.
REQ-011 SHALL have port out_ready, input, 1, consumer acknowledges the result.
REQ-012 SHALL have port data_out, output, 32, shifted result.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE, busy = 1 only in SHIFT, and out_valid = 1 only in DONE.
REQ-015 SHALL accept an operation on the rising edge where start = 1 and in_ready = 1.
- Captures data_in, shamt and arith into internal registers.
- Clears the stage index to 0.
- Moves to SHIFT.
REQ-016 SHALL ignore start in SHIFT and DONE, with no change to captured operands.
REQ-017 SHALL, in SHIFT, apply one log-shifter stage per cycle, with stage k (k = 0..4) shifting the working value right by 2^k when captured shamt[k] = 1, otherwise passing it unchanged.
REQ-018 SHALL fill vacated MSBs with captured bit 31 of the original operand when arith = 1, and with 0 when arith = 0.
REQ-019 SHALL hold the sign bit of the original operand for all stages, not the sign of an intermediate value.
REQ-020 SHALL transition SHIFT -> DONE after stage 4 completes, taking exactly 5 SHIFT cycles regardless of shamt (including shamt = 0).
REQ-021 SHALL assert out_valid on the 5th rising edge after the accept edge.
REQ-022 SHALL hold data_out stable and out_valid high in DONE until an edge with out_ready = 1, then go to IDLE.
REQ-023 SHALL permit out_ready to be high on the same edge that out_valid first rises, with the result consumed on the following edge.
REQ-024 SHALL NOT accept a new operation on the edge that leaves DONE; in_ready rises the cycle after.
REQ-025 SHALL keep data_out at the last result in IDLE and SHIFT until a new result is produced.
REQ-026 SHALL NOT update data_out with intermediate stage values.
REQ-027 SHALL ignore out_ready in IDLE and SHIFT.
REQ-028 SHALL produce results bit-exact with Verilog >> (logical) and >>> on signed 32-bit (arithmetic).

Reset
REQ-029 SHALL, while resetn = 0, asynchronously force:
- state to IDLE;
- in_ready = 1, busy = 0, out_valid = 0;
- data_out = 32'h0;
- all captured operand and stage registers to 0.
REQ-030 SHALL, on reset assertion mid-SHIFT or mid-DONE, abort the operation and discard the result, with no out_valid pulse after release.
REQ-031 SHALL accept start on the first rising edge after resetn deasserts.

Verification
REQ-032 SHALL cover the logical case:
- Stimulus: data_in = 32'h8000_00F0, shamt = 4, arith = 0, out_ready = 1.
- Response: data_out = 32'h0800_000F; out_valid high exactly 5 edges after accept.
REQ-033 SHALL cover the arithmetic full-shift case:
- Stimulus: data_in = 32'h8000_0000, shamt = 31, arith = 1.
- Response: data_out = 32'hFFFF_FFFF.
- Same operand with arith = 0: data_out = 32'h0000_0001.
REQ-034 SHALL cover zero shift:
- Stimulus: data_in = 32'hDEAD_BEEF, shamt = 0, arith = 1.
- Response: data_out = 32'hDEAD_BEEF after the full 5-cycle latency.
REQ-035 SHALL cover backpressure:
- Stimulus: out_ready = 0 for 10 cycles after out_valid rises; start pulsed in DONE with different operands.
- Response: data_out stable, in_ready = 0, second start ignored.
- Then out_ready = 1: IDLE next cycle.
REQ-036 SHALL cover reset mid-operation:
- Stimulus: resetn low at the 3rd SHIFT cycle.
- Response: outputs immediately at reset values; no out_valid after release; a new op (32'h0000_0100 >> 8, logical) returns 32'h0000_0001.
REQ-037 SHALL cover random regression:
- Stimulus: 10,000 random data_in, shamt and arith values with random out_ready stalls.
- Response: every result matches the reference model of REQ-028; no accept while in_ready = 0.
